// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared definitions for the memory pipeline stage.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as a word)
//   - byte_en():       per-byte write enables for a store
//   - store_lanes():   replicate right-aligned store data into every lane
//   - is_misaligned(): natural-alignment check for an access
//   - load_format():   pick the addressed lane from a RAM word and extend it
// All helpers assume a 32-bit data path with little-endian byte lanes.
package stage_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Half accesses only look at off[1]; word accesses ignore the offset.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{data[7:0]}};
            SZ_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stage_mem_pipe_if.sv
// stage_mem_pipe_if: EX/MEM input slot, stall handshake and MEM/WB output slot of the
// memory stage.
//   master: upstream/downstream side (drives *_in, Stall_in; observes *_out, Ready_out)
//   slave:  the stage itself
interface stage_mem_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned RD_W   = 5
);
    // EX/MEM slot and stall
    logic              Valid_in;
    logic              Stall_in;
    logic [DATA_W-1:0] Alu_result_in;
    logic [DATA_W-1:0] Store_data_in;
    logic              Mem_read_in;
    logic              Mem_write_in;
    logic [1:0]        Size_in;
    logic              Unsigned_in;
    logic              Reg_write_in;
    logic [RD_W-1:0]   Rd_in;
    logic [PC_W-1:0]   PC_NEXT_INS_IN;

    // MEM/WB slot
    logic              Ready_out;
    logic              Valid_out;
    logic              Reg_write_out;
    logic [RD_W-1:0]   Rd_out;
    logic [DATA_W-1:0] Alu_result_out;
    logic [DATA_W-1:0] MEM_DATA_OUT;
    logic              Is_load_out;
    logic [PC_W-1:0]   PC_NEXT_INS_OUT;
    logic              Misalign_out;

    modport master (
        output Valid_in, Stall_in, Alu_result_in, Store_data_in, Mem_read_in, Mem_write_in,
               Size_in, Unsigned_in, Reg_write_in, Rd_in, PC_NEXT_INS_IN,
        input  Ready_out, Valid_out, Reg_write_out, Rd_out, Alu_result_out, MEM_DATA_OUT,
               Is_load_out, PC_NEXT_INS_OUT, Misalign_out
    );

    modport slave (
        input  Valid_in, Stall_in, Alu_result_in, Store_data_in, Mem_read_in, Mem_write_in,
               Size_in, Unsigned_in, Reg_write_in, Rd_in, PC_NEXT_INS_IN,
        output Ready_out, Valid_out, Reg_write_out, Rd_out, Alu_result_out, MEM_DATA_OUT,
               Is_load_out, PC_NEXT_INS_OUT, Misalign_out
    );

endinterface

// File: rtl/data_mem_be.sv
// data_mem_be: single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
//   clk_i   clock
//   we_i    per-byte write enable (bit i writes byte lane i)
//   re_i    read enable; rdata_o holds its last value while low
//   addr_i  word address
//   wdata_i write data (already lane-aligned)
//   rdata_o registered read data
// Contents are not reset.
module data_mem_be #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic [DATA_W/8-1:0]   we_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);
    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned Depth    = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumBytes; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stage_mem_pipe.sv
// stage_mem_pipe: memory pipeline stage between execute and write-back.
// Owns the data memory, performs byte/half/word loads and stores with sign/zero extension,
// and registers control and data into the MEM/WB slot with one cycle of latency.
//   Clock_in    clock, rising edge
//   Reset_n_in  synchronous active-low reset
//   bus         stage_mem_pipe_if.slave: EX/MEM inputs, Stall_in/Ready_out, MEM/WB outputs
// Build option: STAGE_MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses (store
// suppressed, load data and Reg_write_out forced to 0, Misalign_out set). Without it the
// offset bits below the access size are ignored and Misalign_out is tied 0.
// The lane helpers assume DATA_W = 32.
module stage_mem_pipe
    import stage_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned RD_W   = 5
) (
    input logic              Clock_in,
    input logic              Reset_n_in,
    stage_mem_pipe_if.slave  bus
);
    logic              accept;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        off;
    logic              is_load;
    logic              is_mem_op;
    logic              misalign;
    logic [3:0]        mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr_hi;

    logic              valid_q;
    logic              reg_write_q;
    logic [RD_W-1:0]   rd_q;
    logic [DATA_W-1:0] alu_q;
    logic              is_load_q;
    logic [PC_W-1:0]   pc_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              load_ok;

    assign accept    = bus.Valid_in & ~bus.Stall_in;
    assign word_idx  = bus.Alu_result_in[ADDR_W+1:2];
    assign off       = bus.Alu_result_in[1:0];
    // Address bits above the RAM wrap around.
    assign unused_addr_hi = ^bus.Alu_result_in[DATA_W-1:ADDR_W+2];

    // A store takes priority over a simultaneous load.
    assign is_load   = bus.Mem_read_in & ~bus.Mem_write_in;
    assign is_mem_op = bus.Mem_read_in | bus.Mem_write_in;

`ifdef STAGE_MEM_MISALIGN_TRAP_EN
    assign misalign = is_mem_op & is_misaligned(bus.Size_in, off);
`else
    assign misalign = 1'b0;
    logic unused_mem_op;
    assign unused_mem_op = is_mem_op;
`endif

    // Reset_n_in gates the RAM so nothing is written or read on a reset edge.
    assign mem_we    = {4{accept & bus.Mem_write_in & ~misalign & Reset_n_in}}
                       & byte_en(bus.Size_in, off);
    assign mem_re    = accept & is_load & Reset_n_in;
    assign mem_wdata = store_lanes(bus.Size_in, bus.Store_data_in);

    data_mem_be #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk_i   (Clock_in),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (word_idx),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // MEM/WB slot. Stall freezes everything; a bubble only clears valid.
    always_ff @(posedge Clock_in) begin
        if (!Reset_n_in) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            alu_q       <= '0;
            is_load_q   <= 1'b0;
            pc_q        <= '0;
            off_q       <= 2'b00;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            reg_write_q <= bus.Reg_write_in & ~misalign;
            rd_q        <= bus.Rd_in;
            alu_q       <= bus.Alu_result_in;
            is_load_q   <= is_load;
            pc_q        <= bus.PC_NEXT_INS_IN;
            off_q       <= off;
            size_q      <= bus.Size_in;
            uns_q       <= bus.Unsigned_in;
        end else if (!bus.Stall_in) begin
            valid_q     <= 1'b0;
        end
    end

`ifdef STAGE_MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge Clock_in) begin
        if (!Reset_n_in) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= misalign;
        end
    end

    assign load_ok          = is_load_q & ~misalign_q;
    assign bus.Misalign_out = misalign_q;
`else
    assign load_ok          = is_load_q;
    assign bus.Misalign_out = 1'b0;
`endif

    assign bus.Ready_out       = ~bus.Stall_in;
    assign bus.Valid_out       = valid_q;
    assign bus.Reg_write_out   = reg_write_q;
    assign bus.Rd_out          = rd_q;
    assign bus.Alu_result_out  = alu_q;
    assign bus.Is_load_out     = is_load_q;
    assign bus.PC_NEXT_INS_OUT = pc_q;
    assign bus.MEM_DATA_OUT    = load_ok ? load_format(mem_rdata, size_q, off_q, uns_q) : '0;

endmodule

// File: tb/tb_stage_mem_pipe.sv
// Scoreboard bench for stage_mem_pipe: a byte-addressed reference memory predicts each
// accepted instruction's MEM/WB slot; a monitor checks every cycle after the clock edge.
module tb_stage_mem_pipe;

    typedef struct packed {
        logic        valid;
        logic        regw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] data;
        logic        ld;
        logic [31:0] pc;
        logic        mis;
    } rec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rec_t       exp_q[$];
    rec_t       cur;
    logic [7:0] ref_mem [4096];

    bit s_seen, s_rst, s_acc, s_stall;

    stage_mem_pipe_if #(.DATA_W(32), .PC_W(32), .RD_W(5)) bus ();

    stage_mem_pipe #(
        .DATA_W (32),
        .ADDR_W (10),
        .PC_W   (32),
        .RD_W   (5)
    ) dut (
        .Clock_in   (clk),
        .Reset_n_in (rst_n),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic int acc_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_mis(input bit mem_op, input logic [1:0] sz, input logic [31:0] a);
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
        return mem_op && ((a % acc_bytes(sz)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Natural alignment: the access covers the aligned n-byte block holding the address.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input bit uns);
        int n;
        int base;
        logic [31:0] v;
        n    = acc_bytes(sz);
        base = int'(a % 4096) / n * n;
        v    = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz,
                                        input logic [31:0] d);
        int n;
        int base;
        n    = acc_bytes(sz);
        base = int'(a % 4096) / n * n;
        for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(d >> (8 * i));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one EX/MEM slot for one cycle; push the expected result if it is accepted.
    task automatic issue(input bit v, input bit st, input bit rd, input bit wr,
                         input logic [1:0] sz, input bit uns, input bit regw,
                         input logic [4:0] rdi, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] pc);
        rec_t e;
        bit   mis;
        bus.Valid_in       = v;
        bus.Stall_in       = st;
        bus.Mem_read_in    = rd;
        bus.Mem_write_in   = wr;
        bus.Size_in        = sz;
        bus.Unsigned_in    = uns;
        bus.Reg_write_in   = regw;
        bus.Rd_in          = rdi;
        bus.Alu_result_in  = a;
        bus.Store_data_in  = sd;
        bus.PC_NEXT_INS_IN = pc;
        if (rst_n && v && !st) begin
            mis     = model_mis(rd || wr, sz, a);
            e.valid = 1'b1;
            e.regw  = regw && !mis;
            e.rd    = rdi;
            e.alu   = a;
            e.ld    = rd && !wr;
            e.data  = (e.ld && !mis) ? model_load(a, sz, uns) : 32'h0;
            e.pc    = pc;
            e.mis   = mis;
            exp_q.push_back(e);
            if (wr && !mis) model_store(a, sz, sd);
        end
        step();
    endtask

    task automatic st_w(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        issue(1, 0, 0, 1, sz, 0, 0, 5'd0, a, d, $urandom);
    endtask

    task automatic ld_w(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        issue(1, 0, 1, 0, sz, uns, 1, 5'($urandom), a, $urandom, $urandom);
    endtask

    // Classify each edge from the bench's own stimulus.
    always @(posedge clk) begin
        s_seen  = 1'b1;
        s_rst   = !rst_n;
        s_acc   = rst_n && bus.Valid_in && !bus.Stall_in;
        s_stall = rst_n && bus.Stall_in;
    end

    always @(negedge clk) begin
        if (s_seen) begin
            if (s_rst) begin
                cur = '0;
            end else if (s_acc) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'd1, 32'd0);
                end else begin
                    chk("accept_valid", 32'(bus.Valid_out), 32'd1);
                    if (bus.Valid_out) cur = exp_q.pop_front();
                end
            end else if (!s_stall) begin
                cur.valid = 1'b0;
            end
            chk("Valid_out", 32'(bus.Valid_out), 32'(cur.valid));
            chk("Reg_write_out", 32'(bus.Reg_write_out), 32'(cur.regw));
            chk("Rd_out", 32'(bus.Rd_out), 32'(cur.rd));
            chk("Alu_result_out", bus.Alu_result_out, cur.alu);
            chk("MEM_DATA_OUT", bus.MEM_DATA_OUT, cur.data);
            chk("Is_load_out", 32'(bus.Is_load_out), 32'(cur.ld));
            chk("PC_NEXT_INS_OUT", bus.PC_NEXT_INS_OUT, cur.pc);
            chk("Misalign_out", 32'(bus.Misalign_out), 32'(cur.mis));
            chk("Ready_out", 32'(bus.Ready_out), 32'(!bus.Stall_in));
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cur    = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

        // Reset with a valid store presented: nothing may be written.
        rst_n = 1'b0;
        issue(1, 0, 0, 1, 2'd2, 0, 1, 5'd3, 32'h80, 32'hAAAA_AAAA, 32'h100);
        issue(1, 0, 0, 1, 2'd2, 0, 1, 5'd3, 32'h80, 32'hAAAA_AAAA, 32'h100);
        rst_n = 1'b1;

        // Fill the low 256 bytes with known data.
        for (int i = 0; i < 64; i++) st_w(32'(4 * i), 2'd2, $urandom);
        st_w(32'h80, 2'd2, 32'h1122_3344);

        // Store stalled, then reset mid-stall: held store is discarded and never written.
        issue(1, 1, 0, 1, 2'd2, 0, 1, 5'd4, 32'h80, 32'hAAAA_AAAA, 32'h104);
        rst_n = 1'b0;
        issue(1, 1, 0, 1, 2'd2, 0, 1, 5'd4, 32'h80, 32'hAAAA_AAAA, 32'h104);
        issue(1, 0, 0, 1, 2'd2, 0, 1, 5'd4, 32'h80, 32'hAAAA_AAAA, 32'h104);
        rst_n = 1'b1;
        ld_w(32'h80, 2'd2, 0);

        // Word store / load back-to-back, then byte and half variants.
        st_w(32'h40, 2'd2, 32'hDEAD_BEEF);
        ld_w(32'h40, 2'd2, 0);
        st_w(32'h41, 2'd0, 32'h0000_0080);
        ld_w(32'h41, 2'd0, 0);
        ld_w(32'h41, 2'd0, 1);
        ld_w(32'h40, 2'd2, 0);
        ld_w(32'h42, 2'd1, 0);
        ld_w(32'h42, 2'd1, 1);
        ld_w(32'hFFFF_F040, 2'd3, 0);

        // Load, then three stalled cycles holding a store, then release.
        ld_w(32'h40, 2'd2, 0);
        for (int i = 0; i < 3; i++)
            issue(1, 1, 0, 1, 2'd2, 0, 0, 5'd7, 32'h40, 32'h5555_5555 + i, 32'h200);
        issue(0, 0, 0, 0, 2'd2, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        ld_w(32'h40, 2'd2, 0);
        issue(1, 1, 1, 0, 2'd0, 0, 1, 5'd9, 32'h43, 32'h0, 32'h300);
        issue(1, 0, 1, 0, 2'd0, 0, 1, 5'd9, 32'h43, 32'h0, 32'h300);

        // Read and write together: the store wins.
        issue(1, 0, 1, 1, 2'd1, 0, 1, 5'd5, 32'h52, 32'h0000_CAFE, 32'h400);
        ld_w(32'h50, 2'd2, 0);

        // Misaligned word store at 0x45 and read-back at 0x44.
        st_w(32'h44, 2'd2, 32'h0BAD_F00D);
        issue(1, 0, 0, 1, 2'd2, 0, 1, 5'd6, 32'h45, 32'h1234_5678, 32'h500);
        ld_w(32'h44, 2'd2, 0);
        ld_w(32'h47, 2'd1, 0);

        // Randomized traffic within the initialised region, with wrap-around upper bits.
        for (int i = 0; i < 400; i++) begin
            int          k;
            logic [31:0] a;
            k = $urandom_range(0, 7);
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            issue(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
                  (k <= 2) || (k == 5), (k == 3) || (k == 4) || (k == 5),
                  2'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), a, $urandom,
                  $urandom);
        end

        issue(0, 0, 0, 0, 2'd0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        issue(0, 0, 0, 0, 2'd0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
